// File: rtl/snake_feeder_pkg.sv
// -----------------------------------------------------------------------------
// Module  : snake_feeder_pkg
// Brief   : Shared layer constants and feeder state encoding.
// Rev     : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

package snake_feeder_pkg;

   localparam int ROW_FIRST_LAYER = 128;
   localparam int COL_FIRST_LAYER = 128;
   localparam int CHANNEL_IN      = 4;
   localparam int PEA_NUM_DEF     = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_SNAKE = 2'd2,
      ST_DRAIN = 2'd3
   } feed_state_t;

endpackage

`default_nettype wire

// File: rtl/feed_skid_fifo.sv
// -----------------------------------------------------------------------------
// Module  : feed_skid_fifo
// Brief   : Two-entry FIFO; head entry is presented straight from storage.
// Rev     : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module feed_skid_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (i_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/snake_feeder.sv
// -----------------------------------------------------------------------------
// Module  : snake_feeder
// Brief   : Streams a feature map from pixel SRAM in prime-then-snake order.
// Rev     : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module snake_feeder
   import snake_feeder_pkg::*;
#(
   parameter int ROW     = ROW_FIRST_LAYER,
   parameter int COL     = COL_FIRST_LAYER,
   parameter int CH_IN   = CHANNEL_IN,
   parameter int PEA_NUM = PEA_NUM_DEF,
   localparam int ADDR_W = $clog2(ROW * COL)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 mem_rd_en,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [CH_IN*8-1:0]   mem_rdata,
   output logic [PEA_NUM*8-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 busy,
   output logic                 done
);

   localparam int DW = CH_IN * 8;
   localparam int RW = $clog2(ROW);
   localparam int CW = (COL > 1) ? $clog2(COL) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

   feed_state_t   r_state, w_state_nxt;
   logic [RW-1:0] r_row, w_row_nxt;
   logic [CW-1:0] r_col, w_col_nxt;
   logic          r_pend;
   logic          w_issue;
   logic          w_pop;
   logic          w_room;
   logic          w_full;
   logic          w_empty;
   logic [1:0]    w_count;
   logic [2:0]    w_load;
   logic [DW-1:0] w_head;

   feed_skid_fifo #(
      .WIDTH (DW)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_pend),
      .i_wdata (mem_rdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign data_valid = !w_empty;
   assign w_pop      = data_valid && data_ready;
   // Count buffered beats plus the read whose data lands this cycle.
   assign w_load     = {1'b0, w_count} + {2'b0, r_pend};
   assign w_room     = w_pop ? (w_load <= 3'd2) : ((w_load < 3'd2) && !w_full);
   assign data_out   = (PEA_NUM * 8)'(w_head);
   assign mem_rd_en  = w_issue;
   assign mem_addr   = ADDR_W'(r_row) * ADDR_W'(COL) + ADDR_W'(r_col);
   assign busy       = (r_state != ST_IDLE);

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_issue     = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_nxt = ST_PRIME;
            end
         end
         ST_PRIME: begin
            if (w_room) begin
               w_issue = 1'b1;
               if (r_row == '0) begin
                  w_row_nxt = RW'(1);
               end else if (r_col != COL_LAST) begin
                  w_row_nxt = '0;
                  w_col_nxt = r_col + CW'(1);
               end else if (ROW == 2) begin
                  w_state_nxt = ST_DRAIN;
                  w_row_nxt   = '0;
                  w_col_nxt   = '0;
               end else begin
                  w_state_nxt = ST_SNAKE;
                  w_row_nxt   = RW'(2);
                  w_col_nxt   = COL_LAST;
               end
            end
         end
         ST_SNAKE: begin
            if (w_room) begin
               w_issue = 1'b1;
               // On a row wrap the column stays put: the next row starts at the same edge.
               if ((!r_row[0] && r_col == '0) || (r_row[0] && r_col == COL_LAST)) begin
                  if (r_row == ROW_LAST) begin
                     w_state_nxt = ST_DRAIN;
                     w_row_nxt   = '0;
                     w_col_nxt   = '0;
                  end else begin
                     w_row_nxt = r_row + RW'(1);
                  end
               end else if (!r_row[0]) begin
                  w_col_nxt = r_col - CW'(1);
               end else begin
                  w_col_nxt = r_col + CW'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (w_empty && !r_pend) begin
               done        = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_pend  <= w_issue;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_snake_feeder.sv
// -----------------------------------------------------------------------------
// Module  : tb_snake_feeder
// Brief   : Scoreboard bench for snake_feeder on 4x3, 2x1 and 128x128 maps.
// Rev     : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_snake_feeder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic ready = 1'b0;
   int   sel = 0;

   always #5 clk = ~clk;

   logic        a_rd_en, a_valid, a_busy, a_done;
   logic [3:0]  a_addr;
   logic [31:0] a_rdata;
   logic [63:0] a_dout;
   logic        b_rd_en, b_valid, b_busy, b_done;
   logic [0:0]  b_addr;
   logic [31:0] b_rdata;
   logic [63:0] b_dout;
   logic        c_rd_en, c_valid, c_busy, c_done;
   logic [13:0] c_addr;
   logic [31:0] c_rdata;
   logic [63:0] c_dout;

   logic        m_valid, m_busy, m_done;
   logic [63:0] m_dout;

   snake_feeder #(.ROW(4), .COL(3), .CH_IN(4), .PEA_NUM(8)) u_a (
      .clk(clk), .rst(rst), .start(start && sel == 0), .mem_rd_en(a_rd_en),
      .mem_addr(a_addr), .mem_rdata(a_rdata), .data_out(a_dout),
      .data_valid(a_valid), .data_ready(ready), .busy(a_busy), .done(a_done));

   snake_feeder #(.ROW(2), .COL(1), .CH_IN(4), .PEA_NUM(8)) u_b (
      .clk(clk), .rst(rst), .start(start && sel == 1), .mem_rd_en(b_rd_en),
      .mem_addr(b_addr), .mem_rdata(b_rdata), .data_out(b_dout),
      .data_valid(b_valid), .data_ready(ready), .busy(b_busy), .done(b_done));

   snake_feeder u_c (
      .clk(clk), .rst(rst), .start(start && sel == 2), .mem_rd_en(c_rd_en),
      .mem_addr(c_addr), .mem_rdata(c_rdata), .data_out(c_dout),
      .data_valid(c_valid), .data_ready(ready), .busy(c_busy), .done(c_done));

   // SRAM models: each word holds its own address, one cycle of read latency.
   always_ff @(posedge clk) begin
      if (a_rd_en) a_rdata <= 32'(a_addr);
      if (b_rd_en) b_rdata <= 32'(b_addr);
      if (c_rd_en) c_rdata <= 32'(c_addr);
   end

   always_comb begin
      m_valid = a_valid; m_dout = a_dout; m_busy = a_busy; m_done = a_done;
      case (sel)
         1: begin m_valid = b_valid; m_dout = b_dout; m_busy = b_busy; m_done = b_done; end
         2: begin m_valid = c_valid; m_dout = c_dout; m_busy = c_busy; m_done = c_done; end
         default: ;
      endcase
   end

   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] exp_q[$];
   int          seq_a[12] = '{0, 3, 1, 4, 2, 5, 8, 7, 6, 9, 10, 11};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_seq_a();
      for (int i = 0; i < 12; i++) exp_q.push_back(64'(seq_a[i]));
   endtask

   task automatic push_model(input int rows, input int cols);
      for (int c = 0; c < cols; c++) begin
         exp_q.push_back(64'(c));
         exp_q.push_back(64'(cols + c));
      end
      for (int r = 2; r < rows; r++) begin
         for (int k = 0; k < cols; k++) begin
            int c = (r % 2 == 0) ? (cols - 1 - k) : k;
            exp_q.push_back(64'(r * cols + c));
         end
      end
   endtask

   // mode 0: ready held high, mode 1: ready toggles every cycle.
   task automatic run_frame(input int mode, input int budget, input int abort_at, input bit spam,
                            output int beats, output int dones, output int gaps);
      int          cyc = 0;
      int          last_xfer = -10;
      bit          fin = 0;
      bit          stalled = 0;
      logic [63:0] held = '0;
      beats = 0; dones = 0; gaps = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = spam;
      chk("busy_after_start", m_busy, 1);
      chk("no_early_valid", m_valid, 0);
      while (!fin && cyc < budget) begin
         ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
         @(negedge clk);
         if (stalled) chk("stall_hold", m_dout, held);
         if (m_valid && ready) begin
            if (exp_q.size() == 0) chk("extra_beat", 1, 0);
            else chk($sformatf("beat%0d", beats), m_dout, exp_q.pop_front());
            beats++;
            last_xfer = cyc;
         end else if (!m_valid && beats > 0 && exp_q.size() > 0) begin
            gaps++;
         end
         stalled = m_valid && !ready;
         held    = m_dout;
         if (m_done) begin
            dones++;
            chk("done_latency", 64'(cyc - last_xfer), 1);
            fin = 1;
         end
         @(posedge clk); #1;
         if (abort_at > 0 && beats == abort_at && !fin) begin
            rst = 1'b1;
            fin = 1;
         end
         cyc++;
      end
      if (!fin) chk("timeout", 0, 1);
      start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk({tag, "_busy"}, m_busy, 0);
      chk({tag, "_valid"}, m_valid, 0);
      chk({tag, "_done"}, m_done, 0);
   endtask

   int beats, dones, gaps;

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", a_rd_en, 0);
      chk("rst_addr", 64'(a_addr), 0);
      chk("rst_dout", a_dout, 0);
      chk("rst_valid", a_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      @(posedge clk); #1 rst = 1'b0;

      // 4x3, ready held high
      push_seq_a();
      run_frame(0, 200, 0, 0, beats, dones, gaps);
      chk("a_ready_beats", 64'(beats), 12);
      chk("a_ready_dones", 64'(dones), 1);
      chk("a_ready_gaps", 64'(gaps), 0);
      check_idle("a_ready_idle");

      // 4x3, ready toggling
      push_seq_a();
      run_frame(1, 200, 0, 0, beats, dones, gaps);
      chk("a_toggle_beats", 64'(beats), 12);
      chk("a_toggle_dones", 64'(dones), 1);
      check_idle("a_toggle_idle");

      // abort after beat 5, then a clean frame
      push_seq_a();
      run_frame(0, 200, 6, 0, beats, dones, gaps);
      chk("abort_dones", 64'(dones), 0);
      @(negedge clk);
      chk("abort_valid", m_valid, 0);
      chk("abort_busy", m_busy, 0);
      chk("abort_done", m_done, 0);
      @(posedge clk); #1 rst = 1'b0;
      exp_q.delete();
      push_seq_a();
      run_frame(0, 200, 0, 0, beats, dones, gaps);
      chk("post_abort_beats", 64'(beats), 12);
      chk("post_abort_dones", 64'(dones), 1);
      check_idle("post_abort_idle");

      // start held high through the whole frame including the done cycle
      push_seq_a();
      run_frame(0, 200, 0, 1, beats, dones, gaps);
      chk("spam_beats", 64'(beats), 12);
      chk("spam_dones", 64'(dones), 1);
      check_idle("spam_idle");
      check_idle("spam_idle2");

      // 2x1
      sel = 1;
      exp_q.push_back(64'd0);
      exp_q.push_back(64'd1);
      run_frame(0, 50, 0, 0, beats, dones, gaps);
      chk("b_beats", 64'(beats), 2);
      chk("b_dones", 64'(dones), 1);
      check_idle("b_idle");

      // 128x128 full layer
      sel = 2;
      push_model(128, 128);
      run_frame(0, 20000, 0, 0, beats, dones, gaps);
      chk("c_beats", 64'(beats), 16384);
      chk("c_dones", 64'(dones), 1);
      chk("c_gaps", 64'(gaps), 0);
      chk("c_queue_empty", 64'(exp_q.size()), 0);
      check_idle("c_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/snake_feeder.md
SNAKE_FEEDER -- requirements
Module: snake_feeder

Interface
REQ-001 Parameter ROW, default `ROW_first_layer (128), feature-map rows; legal range ROW >= 2.
REQ-002 Parameter COL, default `COL_first_layer (128), feature-map columns; legal range COL >= 1.
REQ-003 Parameter CH_IN, default `CHANNEL_IN (4), channels packed per pixel, 8 bits each.
REQ-004 Parameter PEA_NUM, default `PEA_num, output lanes, 8 bits each; PEA_NUM >= CH_IN.
REQ-005 Derived ADDR_W = clog2(ROW*COL).
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that launches one frame; honoured only in IDLE.
REQ-009 mem_rd_en  output  1  read strobe to pixel SRAM.
REQ-010 mem_addr  output  ADDR_W  pixel address, row*COL + col.
REQ-011 mem_rdata  input  CH_IN*8  pixel word, valid exactly 1 cycle after mem_rd_en.
REQ-012 data_out  output  PEA_NUM*8  pixel word in bits [CH_IN*8-1:0]; upper bits zero.
REQ-013 data_valid  output  1  data_out holds a beat.
REQ-014 data_ready  input  1  downstream PE array accepts; transfer when valid && ready.
REQ-015 busy  output  1  high from accepted start until done.
REQ-016 done  output  1  one-cycle pulse after the last beat transfers.

Function
REQ-017 Frame beat order: priming phase, then snake phase; ROW*COL beats total, each pixel exactly once.
REQ-018 Priming: for col 0..COL-1, emit (row0,col) then (row1,col).
REQ-019 Snake: for row 2..ROW-1; even row scans col COL-1 down to 0, odd row scans col 0 up to COL-1.
REQ-020 States IDLE -> PRIME (on start) -> SNAKE (after pixel (1,COL-1) issued; if ROW==2 skip to DRAIN) -> DRAIN (after last read issued) -> IDLE (when buffer empty and no read in flight; done pulses that cycle).
REQ-021 Read issue rule: issue when (occupancy + in_flight - pop_this_cycle) < 2; sustains 1 beat/cycle with data_ready held high.
REQ-022 Two-entry output buffer, FIFO order; data_out/data_valid driven from head entry, registered.
REQ-023 While data_valid && !data_ready, data_out stays stable; no beat dropped or duplicated.
REQ-024 First data_valid no earlier than 2 cycles after start (issue cycle + SRAM latency).
REQ-025 start while busy: ignored, no effect on counters.
REQ-026 Column counter wraps at COL-1 / 0 per direction; row counter increments on each wrap; no address outside 0..ROW*COL-1.
REQ-027 done and a new start in the same cycle: start ignored (state not yet IDLE).

Reset
REQ-028 On rst: state IDLE, counters 0, buffer empty, in_flight 0.
REQ-029 Reset values: mem_rd_en 0, mem_addr 0, data_out 0, data_valid 0, busy 0, done 0.
REQ-030 rst mid-frame aborts immediately; any SRAM data returning after reset is discarded; no done pulse.

Structure
REQ-031 ROW/COL/CH_IN/PEA_NUM defaults and state encoding come from the shared para.v constants file.
REQ-032 The 2-entry buffer is a sub-module feed_skid_fifo (width CH_IN*8, push/pop/full/empty/count).
REQ-033 Address generation (counters, direction, phase) stays in snake_feeder.

Verification
REQ-034 ROW=4,COL=3, SRAM word = address, ready=1: data_out low byte sequence 0,3,1,4,2,5,8,7,6,9,10,11; done once, 1 cycle after beat 11.
REQ-035 Same config, ready toggling 1/0 every cycle: identical 12-beat sequence; data_out constant across every stalled cycle.
REQ-036 ROW=2,COL=1: beats 0,1 only; SNAKE never entered; done after beat 1.
REQ-037 rst asserted after beat 5 of REQ-034 frame: next cycle valid=0, busy=0; new start yields full sequence from 0, no stale beat.
REQ-038 Extra start pulses during frame and coincident with done: sequence and beat count unchanged (12), single done.
REQ-039 ROW=128,COL=128, ready=1: 16384 beats in 16384 consecutive valid cycles after first beat; upper PEA_NUM*8-CH_IN*8 bits always zero.
